// File: rtl/alu_pkg.sv
// Shared encodings for the execute-stage ALU: operation codes, funct codes
// and main-control ALUOp values.
package alu_pkg;

    // Decoded ALU operation (the gout bus). Code 3'b101 is unused and yields 0.
    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_ADD = 3'b010,
        OP_XOR = 3'b011,
        OP_NOR = 3'b100,
        OP_SUB = 3'b110,
        OP_SLT = 3'b111
    } alu_op_e;

    // R-type funct field values
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_XOR = 6'b100110;
    localparam logic [5:0] FUNCT_NOR = 6'b100111;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    // ALUOp from the main control unit; any value with bit 1 set means R-type
    localparam logic [1:0] ALUOP_ADD = 2'b00;
    localparam logic [1:0] ALUOP_SUB = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

endpackage

// File: rtl/alu_exec_unit_if.sv
// Execute-stage bus: operands and control in, ALU/adder results and status out.
interface alu_exec_unit_if;
    logic [1:0]  aluop;
    logic [5:0]  funct;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pc;
    logic [31:0] imm_ext;
    logic        flag_we;
    logic [2:0]  gout;
    logic [31:0] result;
    logic        zero;
    logic        neg;
    logic [31:0] pc_plus4;
    logic [31:0] br_target;
    logic [1:0]  asreg;

    // Driver side (decode/register-file stage)
    modport master (
        output aluop, funct, a, b, pc, imm_ext, flag_we,
        input  gout, result, zero, neg, pc_plus4, br_target, asreg
    );

    // Execute unit side
    modport slave (
        input  aluop, funct, a, b, pc, imm_ext, flag_we,
        output gout, result, zero, neg, pc_plus4, br_target, asreg
    );
endinterface

// File: rtl/adder32.sv
// 32-bit combinational adder, wraps modulo 2^32.
module adder32 (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] sum_o
);
    assign sum_o = a_i + b_i;
endmodule

// File: rtl/alu_exec_unit.sv
// Execute stage: ALU control decode, 32-bit ALU, PC+4 / branch-target adders
// and the {N, Z} status register consumed by branch/jump control.
module alu_exec_unit
    import alu_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    alu_exec_unit_if.slave   bus
);
    alu_op_e            op;
    logic signed [31:0] a_s;
    logic signed [31:0] b_s;
    logic [31:0]        result;
    logic [1:0]         asreg_d;
    logic [1:0]         asreg_q;
    logic [31:0]        pc_plus4;
    logic [31:0]        br_offset;

    assign a_s = bus.a;
    assign b_s = bus.b;

    // ALU control: ALUOp selects add/sub directly, otherwise funct decides
    always_comb begin
        op = OP_ADD;
        if (bus.aluop[1]) begin
            case (bus.funct)
                FUNCT_ADD: op = OP_ADD;
                FUNCT_SUB: op = OP_SUB;
                FUNCT_AND: op = OP_AND;
                FUNCT_OR:  op = OP_OR;
                FUNCT_XOR: op = OP_XOR;
                FUNCT_NOR: op = OP_NOR;
                FUNCT_SLT: op = OP_SLT;
                default:   op = OP_ADD;
            endcase
        end else if (bus.aluop == ALUOP_SUB) begin
            op = OP_SUB;
        end else begin
            op = OP_ADD;
        end
    end

    // ALU datapath; slt uses a true signed compare so it is correct on overflow
    always_comb begin
        result = 32'd0;
        case (op)
            OP_AND:  result = bus.a & bus.b;
            OP_OR:   result = bus.a | bus.b;
            OP_ADD:  result = bus.a + bus.b;
            OP_SUB:  result = bus.a - bus.b;
            OP_XOR:  result = bus.a ^ bus.b;
            OP_NOR:  result = ~(bus.a | bus.b);
            OP_SLT:  result = (a_s < b_s) ? 32'd1 : 32'd0;
            default: result = 32'd0;
        endcase
    end

    assign bus.gout   = op;
    assign bus.result = result;
    assign bus.zero   = (result == 32'd0);
    assign bus.neg    = result[31];

    assign br_offset = {bus.imm_ext[29:0], 2'b00};

    adder32 u_pc_plus4 (
        .a_i   (bus.pc),
        .b_i   (32'h0000_0004),
        .sum_o (pc_plus4)
    );

    adder32 u_br_target (
        .a_i   (pc_plus4),
        .b_i   (br_offset),
        .sum_o (bus.br_target)
    );

    assign bus.pc_plus4 = pc_plus4;

    // Next status value: capture {N, Z} of this cycle's result when enabled
    always_comb begin
        asreg_d = asreg_q;
        if (bus.flag_we) begin
            asreg_d = {result[31], (result == 32'd0)};
        end
    end

    // Status register; asynchronous reset takes priority over the write enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            asreg_q <= 2'b00;
        end else begin
            asreg_q <= asreg_d;
        end
    end

    assign bus.asreg = asreg_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit with a scoreboard of expected outputs.
module tb_alu_exec_unit;

    typedef struct {
        string       tag;
        logic [2:0]  gout;
        logic [31:0] result;
        logic        zero;
        logic        neg;
        logic [31:0] pc4;
        logic [31:0] br;
    } exp_t;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;
    exp_t sb[$];

    alu_exec_unit_if bus ();

    alu_exec_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one operation and push its expected outputs
    task automatic drive(input string tag, input logic [1:0] aluop, input logic [5:0] funct,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] pc, input logic [31:0] imm, input logic we,
                         input logic [2:0] e_gout, input logic [31:0] e_res,
                         input logic [31:0] e_pc4, input logic [31:0] e_br);
        exp_t e;
        bus.aluop = aluop; bus.funct = funct; bus.a = a; bus.b = b;
        bus.pc = pc; bus.imm_ext = imm; bus.flag_we = we;
        e.tag = tag; e.gout = e_gout; e.result = e_res;
        e.zero = (e_res == 32'd0); e.neg = e_res[31];
        e.pc4 = e_pc4; e.br = e_br;
        sb.push_back(e);
    endtask

    // Pop the oldest expectation and compare against the settled outputs
    task automatic check_out();
        exp_t e;
        #1;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({e.tag, ".gout"},   {29'd0, bus.gout}, {29'd0, e.gout});
            chk({e.tag, ".result"}, bus.result, e.result);
            chk({e.tag, ".zero"},   {31'd0, bus.zero}, {31'd0, e.zero});
            chk({e.tag, ".neg"},    {31'd0, bus.neg},  {31'd0, e.neg});
            chk({e.tag, ".pc4"},    bus.pc_plus4, e.pc4);
            chk({e.tag, ".br"},     bus.br_target, e.br);
        end
    endtask

    task automatic check_asreg(input string tag, input logic [1:0] exp);
        chk(tag, {30'd0, bus.asreg}, {30'd0, exp});
    endtask

    task automatic edge_then_settle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0;
        drive("idle", 2'b00, 6'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1,
              3'b010, 32'd0, 32'd4, 32'd4);
        check_out();
        check_asreg("reset_asreg", 2'b00);
        edge_then_settle();
        check_asreg("reset_holds_over_edge", 2'b00);
        rst_n = 1'b1;

        // R-type sub producing a negative result, captured into asreg
        drive("sub_neg", 2'b10, 6'b100010, 32'd5, 32'd7, 32'd0, 32'd0, 1'b1,
              3'b110, 32'hFFFF_FFFE, 32'd4, 32'd4);
        check_out();
        edge_then_settle();
        check_asreg("asreg_neg", 2'b10);

        // Branch-style subtract of equal operands sets Z
        drive("beq_eq", 2'b01, 6'd0, 32'h1234, 32'h1234, 32'd0, 32'd0, 1'b1,
              3'b110, 32'd0, 32'd4, 32'd4);
        check_out();
        edge_then_settle();
        check_asreg("asreg_zero", 2'b01);

        // flag_we low: new negative result must not be captured
        drive("hold", 2'b01, 6'd0, 32'd1, 32'd2, 32'd0, 32'd0, 1'b0,
              3'b110, 32'hFFFF_FFFF, 32'd4, 32'd4);
        check_out();
        edge_then_settle();
        check_asreg("asreg_hold", 2'b01);

        // Signed set-less-than, including the overflowing operand pairs
        drive("slt_min", 2'b10, 6'b101010, 32'h8000_0000, 32'd1, 32'd0, 32'd0, 1'b0,
              3'b111, 32'd1, 32'd4, 32'd4);
        check_out();
        drive("slt_max", 2'b10, 6'b101010, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0,
              3'b111, 32'd0, 32'd4, 32'd4);
        check_out();

        // Logic operations
        drive("and", 2'b10, 6'b100100, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0, 32'd0, 1'b0,
              3'b000, 32'hF000_F000, 32'd4, 32'd4);
        check_out();
        drive("or", 2'b10, 6'b100101, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0, 32'd0, 1'b0,
              3'b001, 32'hFFF0_FFF0, 32'd4, 32'd4);
        check_out();
        drive("xor", 2'b10, 6'b100110, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0, 32'd0, 1'b0,
              3'b011, 32'h0FF0_0FF0, 32'd4, 32'd4);
        check_out();
        drive("nor", 2'b10, 6'b100111, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0, 32'd0, 1'b0,
              3'b100, 32'h000F_000F, 32'd4, 32'd4);
        check_out();

        // Adds: load/store add with wrap, aluop=11 R-type add, unknown funct
        drive("add_wrap", 2'b00, 6'b100010, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 1'b0,
              3'b010, 32'd0, 32'd4, 32'd4);
        check_out();
        drive("add_11", 2'b11, 6'b100000, 32'd100, 32'd23, 32'd0, 32'd0, 1'b0,
              3'b010, 32'd123, 32'd4, 32'd4);
        check_out();
        drive("funct_unk", 2'b10, 6'b111111, 32'd3, 32'd4, 32'd0, 32'd0, 1'b0,
              3'b010, 32'd7, 32'd4, 32'd4);
        check_out();

        // PC adders: backward branch and PC wrap
        drive("br_back", 2'b00, 6'd0, 32'd0, 32'd0, 32'h0000_001C, 32'hFFFF_FFFE, 1'b0,
              3'b010, 32'd0, 32'h0000_0020, 32'h0000_0018);
        check_out();
        drive("pc_wrap", 2'b00, 6'd0, 32'd0, 32'd0, 32'hFFFF_FFFC, 32'd0, 1'b0,
              3'b010, 32'd0, 32'd0, 32'd0);
        check_out();
        drive("br_fwd", 2'b00, 6'd0, 32'd0, 32'd0, 32'h0000_1000, 32'h0000_0010, 1'b0,
              3'b010, 32'd0, 32'h0000_1004, 32'h0000_1044);
        check_out();

        // Load N into asreg, then drop reset mid-cycle: clears with no edge
        drive("set_n", 2'b01, 6'd0, 32'd0, 32'd1, 32'd0, 32'd0, 1'b1,
              3'b110, 32'hFFFF_FFFF, 32'd4, 32'd4);
        check_out();
        edge_then_settle();
        check_asreg("asreg_before_rst", 2'b10);
        #2;
        rst_n = 1'b0;
        #1;
        check_asreg("async_reset", 2'b00);
        // Reset held across an edge with flag_we high: reset wins
        edge_then_settle();
        check_asreg("reset_wins", 2'b00);
        // Release mid-cycle: no change until the next rising edge
        #2;
        rst_n = 1'b1;
        #1;
        check_asreg("release_no_edge", 2'b00);
        edge_then_settle();
        check_asreg("after_release_edge", 2'b10);

        chk("scoreboard_drained", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
